// File: rtl/max_pooling_pkg.sv
// Shared definitions for the 2x2 max-pooling block: window position codes,
// a constant-safe log2 helper and the signed compare used per feature unit.
package max_pooling_pkg;

   localparam logic [1:0] POS_UL = 2'b00;
   localparam logic [1:0] POS_UR = 2'b01;
   localparam logic [1:0] POS_LL = 2'b10;
   localparam logic [1:0] POS_LR = 2'b11;

   // Units are sign-extended to this width before comparing, so any
   // FIXED_BITW up to 64 shares a single max function.
   localparam int MAX_VW = 64;

   // Ceiling log2, clamped to at least 1 so degenerate parameters still elaborate.
   function automatic int log2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Returns a unless b is strictly greater, so the first operand wins ties.
   function automatic logic signed [MAX_VW-1:0] smax(input logic signed [MAX_VW-1:0] a,
                                                     input logic signed [MAX_VW-1:0] b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer holding the horizontal maxima of the even row.
// One synchronous write port, one asynchronous read port; storage is never reset.
module pool_line_buffer #(
   parameter int DEPTH = 2,
   parameter int AW    = 1,
   parameter int DW    = 8
) (
   input  logic          clock,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/max_pooling.sv
// 2x2 stride-2 signed max pooling over a streamed frame, one pooled pixel per
// completed window. Optional argmax output enabled by MAX_POOLING_ARGMAX_EN.
module max_pooling
   import max_pooling_pkg::*;
#(
   parameter int WIDTH      = -1,
   parameter int HEIGHT     = -1,
   parameter int FIXED_BITW = -1,
   parameter int UNITS      = -1,
   localparam int BW  = (FIXED_BITW > 0) ? FIXED_BITW : 1,
   localparam int NU  = (UNITS > 0) ? UNITS : 1,
   localparam int VW  = log2_f(HEIGHT),
   localparam int HW  = log2_f(WIDTH),
   localparam int OVW = (VW > 1) ? VW - 1 : 1,
   localparam int OHW = (HW > 1) ? HW - 1 : 1
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               in_enable,
   input  logic [BW*NU-1:0]   in_pixels,
   input  logic [VW-1:0]      in_vcnt,
   input  logic [HW-1:0]      in_hcnt,
   output logic               out_enable,
   output logic [BW*NU-1:0]   out_pixels,
`ifdef MAX_POOLING_ARGMAX_EN
   output logic [2*NU-1:0]    out_index,
`endif
   output logic [OVW-1:0]     out_vcnt,
   output logic [OHW-1:0]     out_hcnt
);

   localparam int DEPTH = (WIDTH >= 2) ? WIDTH / 2 : 1;
   localparam int PW    = BW * NU;
`ifdef MAX_POOLING_ARGMAX_EN
   localparam int EW    = PW + NU;
`else
   localparam int EW    = PW;
`endif

   logic [PW-1:0]    pair_q;
   logic             pair_valid_q, pair_valid_d;
   logic [DEPTH-1:0] lb_valid_q, lb_valid_d;
   logic             out_enable_q, out_enable_d;
   logic [PW-1:0]    out_pixels_q, out_pixels_d;
   logic [OVW-1:0]   out_vcnt_q, out_vcnt_d;
   logic [OHW-1:0]   out_hcnt_q, out_hcnt_d;

   logic [OHW-1:0]   lb_addr;
   logic [EW-1:0]    lb_wr_data, lb_rd_data;
   logic [PW-1:0]    lb_rd_max;
   logic             odd_fire, lb_wr_en, out_fire;

   logic [PW-1:0]    hmax, vmax;
   logic signed [MAX_VW-1:0] a_ext, b_ext, t_ext, h_ext;

`ifdef MAX_POOLING_ARGMAX_EN
   logic [NU-1:0]    hsel, lb_rd_hsel;
   logic [2*NU-1:0]  idx_win;
   logic [2*NU-1:0]  out_index_q, out_index_d;
   assign lb_wr_data = {hmax, hsel};
   assign lb_rd_hsel = lb_rd_data[NU-1:0];
   assign lb_rd_max  = lb_rd_data[EW-1 -: PW];
`else
   assign lb_wr_data = hmax;
   assign lb_rd_max  = lb_rd_data;
`endif

   assign lb_addr  = OHW'(in_hcnt >> 1);
   // An odd-column pixel only completes a pair if its left neighbour arrived since reset.
   assign odd_fire = in_enable & in_hcnt[0] & pair_valid_q;
   assign lb_wr_en = odd_fire & ~in_vcnt[0];
   assign out_fire = odd_fire & in_vcnt[0] & lb_valid_q[lb_addr];

   always_comb begin
      a_ext = '0;
      b_ext = '0;
      t_ext = '0;
      h_ext = '0;
      hmax  = '0;
      vmax  = '0;
`ifdef MAX_POOLING_ARGMAX_EN
      hsel    = '0;
      idx_win = '0;
`endif
      for (int u = 0; u < NU; u++) begin
         a_ext = MAX_VW'($signed(pair_q[(NU-1-u)*BW +: BW]));
         b_ext = MAX_VW'($signed(in_pixels[(NU-1-u)*BW +: BW]));
         hmax[(NU-1-u)*BW +: BW] = BW'(smax(a_ext, b_ext));
         t_ext = MAX_VW'($signed(lb_rd_max[(NU-1-u)*BW +: BW]));
         h_ext = MAX_VW'($signed(hmax[(NU-1-u)*BW +: BW]));
         vmax[(NU-1-u)*BW +: BW] = BW'(smax(t_ext, h_ext));
`ifdef MAX_POOLING_ARGMAX_EN
         hsel[u] = (smax(a_ext, b_ext) != a_ext);
         if (smax(t_ext, h_ext) != t_ext)
            idx_win[(NU-1-u)*2 +: 2] = hsel[u] ? POS_LR : POS_LL;
         else
            idx_win[(NU-1-u)*2 +: 2] = lb_rd_hsel[u] ? POS_UR : POS_UL;
`endif
      end
   end

   always_comb begin
      pair_valid_d = in_enable ? ~in_hcnt[0] : pair_valid_q;
      lb_valid_d   = lb_valid_q;
      out_enable_d = out_fire;
      out_pixels_d = out_pixels_q;
      out_vcnt_d   = out_vcnt_q;
      out_hcnt_d   = out_hcnt_q;
`ifdef MAX_POOLING_ARGMAX_EN
      out_index_d  = out_index_q;
`endif
      if (lb_wr_en) lb_valid_d[lb_addr] = 1'b1;
      if (out_fire) begin
         lb_valid_d[lb_addr] = 1'b0;
         out_pixels_d = vmax;
         out_vcnt_d   = OVW'(in_vcnt >> 1);
         out_hcnt_d   = lb_addr;
`ifdef MAX_POOLING_ARGMAX_EN
         out_index_d  = idx_win;
`endif
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         pair_valid_q <= 1'b0;
         lb_valid_q   <= '0;
         out_enable_q <= 1'b0;
         out_pixels_q <= '0;
         out_vcnt_q   <= '0;
         out_hcnt_q   <= '0;
`ifdef MAX_POOLING_ARGMAX_EN
         out_index_q  <= '0;
`endif
      end else begin
         pair_valid_q <= pair_valid_d;
         lb_valid_q   <= lb_valid_d;
         out_enable_q <= out_enable_d;
         out_pixels_q <= out_pixels_d;
         out_vcnt_q   <= out_vcnt_d;
         out_hcnt_q   <= out_hcnt_d;
`ifdef MAX_POOLING_ARGMAX_EN
         out_index_q  <= out_index_d;
`endif
      end
   end

   // Pair data is qualified by pair_valid_q, so it needs no reset.
   always_ff @(posedge clock) begin
      if (in_enable && !in_hcnt[0]) pair_q <= in_pixels;
   end

   pool_line_buffer #(
      .DEPTH (DEPTH),
      .AW    (OHW),
      .DW    (EW)
   ) u_line_buffer (
      .clock     (clock),
      .wr_en_i   (lb_wr_en),
      .wr_addr_i (lb_addr),
      .wr_data_i (lb_wr_data),
      .rd_addr_i (lb_addr),
      .rd_data_o (lb_rd_data)
   );

   assign out_enable = out_enable_q;
   assign out_pixels = out_pixels_q;
   assign out_vcnt   = out_vcnt_q;
   assign out_hcnt   = out_hcnt_q;
`ifdef MAX_POOLING_ARGMAX_EN
   assign out_index  = out_index_q;
`endif

endmodule

// File: tb/tb_max_pooling.sv
// Directed bench for max_pooling: 4x4 frames with 8-bit values, one UNITS=1
// instance and one UNITS=2 instance; argmax checks when MAX_POOLING_ARGMAX_EN is set.
module tb_max_pooling;

   logic clock = 1'b0;
   logic rst;
   always #5 clock = ~clock;

   logic        en1;
   logic [7:0]  pix1;
   logic [1:0]  v1, h1;
   logic        oen1;
   logic [7:0]  opix1;
   logic [0:0]  ov1, oh1;

   logic        en2;
   logic [15:0] pix2;
   logic [1:0]  v2, h2;
   logic        oen2;
   logic [15:0] opix2;
   logic [0:0]  ov2, oh2;

`ifdef MAX_POOLING_ARGMAX_EN
   logic [1:0]  oidx1;
   logic [3:0]  oidx2;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_frame [4];

   max_pooling #(.WIDTH(4), .HEIGHT(4), .FIXED_BITW(8), .UNITS(1)) dut (
      .clock      (clock),
      .rst        (rst),
      .in_enable  (en1),
      .in_pixels  (pix1),
      .in_vcnt    (v1),
      .in_hcnt    (h1),
      .out_enable (oen1),
      .out_pixels (opix1),
`ifdef MAX_POOLING_ARGMAX_EN
      .out_index  (oidx1),
`endif
      .out_vcnt   (ov1),
      .out_hcnt   (oh1)
   );

   max_pooling #(.WIDTH(4), .HEIGHT(4), .FIXED_BITW(8), .UNITS(2)) dut2 (
      .clock      (clock),
      .rst        (rst),
      .in_enable  (en2),
      .in_pixels  (pix2),
      .in_vcnt    (v2),
      .in_hcnt    (h2),
      .out_enable (oen2),
      .out_pixels (opix2),
`ifdef MAX_POOLING_ARGMAX_EN
      .out_index  (oidx2),
`endif
      .out_vcnt   (ov2),
      .out_hcnt   (oh2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One accepted pixel on dut, then `gap` idle cycles; checks after every edge.
   task automatic px(input int v, input int h, input logic [7:0] d, input bit exp_out,
                     input logic [7:0] exp_d, input logic [1:0] exp_i, input int gap);
      @(negedge clock);
      en1  = 1'b1;
      v1   = v[1:0];
      h1   = h[1:0];
      pix1 = d;
      @(posedge clock);
      #1;
      en1 = 1'b0;
      chk("out_enable", {63'd0, oen1}, {63'd0, exp_out});
      if (exp_out) begin
         chk("out_pixels", {56'd0, opix1}, {56'd0, exp_d});
         chk("out_vcnt", {63'd0, ov1}, 64'(v >> 1));
         chk("out_hcnt", {63'd0, oh1}, 64'(h >> 1));
`ifdef MAX_POOLING_ARGMAX_EN
         chk("out_index", {62'd0, oidx1}, {62'd0, exp_i});
`endif
      end
      for (int g = 0; g < gap; g++) begin
         @(posedge clock);
         #1;
         chk("gap_out_enable", {63'd0, oen1}, 64'd0);
         if (exp_out) chk("hold_pixels", {56'd0, opix1}, {56'd0, exp_d});
      end
   endtask

   task automatic frame(input int gap);
      for (int v = 0; v < 4; v++) begin
         for (int h = 0; h < 4; h++) begin
            px(v, h, 8'(v * 4 + h + 1), (v % 2 == 1) && (h % 2 == 1),
               exp_frame[(v / 2) * 2 + h / 2], 2'b11, gap);
         end
      end
   endtask

   task automatic window(input logic [7:0] ul, input logic [7:0] ur, input logic [7:0] ll,
                         input logic [7:0] lr, input logic [7:0] exp_d, input logic [1:0] exp_i);
      px(0, 0, ul, 1'b0, 8'd0, 2'b00, 0);
      px(0, 1, ur, 1'b0, 8'd0, 2'b00, 0);
      px(1, 0, ll, 1'b0, 8'd0, 2'b00, 0);
      px(1, 1, lr, 1'b1, exp_d, exp_i, 1);
   endtask

   task automatic px2(input int v, input int h, input logic [15:0] d);
      @(negedge clock);
      en2  = 1'b1;
      v2   = v[1:0];
      h2   = h[1:0];
      pix2 = d;
      @(posedge clock);
      #1;
      en2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_frame[0] = 8'd6;
      exp_frame[1] = 8'd8;
      exp_frame[2] = 8'd14;
      exp_frame[3] = 8'd16;
      rst = 1'b1;
      en1 = 1'b0; pix1 = '0; v1 = '0; h1 = '0;
      en2 = 1'b0; pix2 = '0; v2 = '0; h2 = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_enable", {63'd0, oen1}, 64'd0);
      chk("rst_out_pixels", {56'd0, opix1}, 64'd0);
      chk("rst_out_vcnt", {63'd0, ov1}, 64'd0);
      chk("rst_out_hcnt", {63'd0, oh1}, 64'd0);
      chk("rst_out_pixels2", {48'd0, opix2}, 64'd0);
`ifdef MAX_POOLING_ARGMAX_EN
      chk("rst_out_index", {62'd0, oidx1}, 64'd0);
`endif
      @(negedge clock);
      rst = 1'b0;

      // Continuous frame, then the same frame with 3 idle cycles between pixels.
      frame(0);
      @(posedge clock);
      #1;
      chk("idle_out_enable", {63'd0, oen1}, 64'd0);
      chk("idle_hold_pixels", {56'd0, opix1}, 64'd16);
      frame(3);

      // Signed extremes and ties.
      window(8'h80, 8'hFF, 8'hFB, 8'hFE, 8'hFF, 2'b01);
      window(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 2'b00);

      // Async reset mid-row 0: the half-built window must be discarded.
      px(0, 0, 8'd1, 1'b0, 8'd0, 2'b00, 0);
      px(0, 1, 8'd2, 1'b0, 8'd0, 2'b00, 0);
      px(0, 2, 8'd3, 1'b0, 8'd0, 2'b00, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_pixels", {56'd0, opix1}, 64'd0);
      chk("async_rst_out_enable", {63'd0, oen1}, 64'd0);
      @(negedge clock);
      rst = 1'b0;
      px(0, 3, 8'd4, 1'b0, 8'd0, 2'b00, 0);
      for (int h = 0; h < 4; h++) px(1, h, 8'(5 + h), 1'b0, 8'd0, 2'b00, 0);
      for (int v = 2; v < 4; v++) begin
         for (int h = 0; h < 4; h++) begin
            px(v, h, 8'(v * 4 + h + 1), (v == 3) && (h % 2 == 1),
               (h < 2) ? 8'd14 : 8'd16, 2'b11, 0);
         end
      end

      // Two units per pixel, unit 0 in the upper byte.
      px2(0, 0, {8'd1, 8'hFD});
      px2(0, 1, {8'd9, 8'hF9});
      px2(1, 0, {8'd3, 8'hFF});
      chk("u2_no_early_out", {63'd0, oen2}, 64'd0);
      px2(1, 1, {8'd4, 8'hF8});
      chk("u2_out_enable", {63'd0, oen2}, 64'd1);
      chk("u2_out_pixels", {48'd0, opix2}, 64'h09FF);
      chk("u2_out_coords", {62'd0, ov2, oh2}, 64'd0);
`ifdef MAX_POOLING_ARGMAX_EN
      chk("u2_out_index", {60'd0, oidx2}, 64'b0110);
`endif
      @(posedge clock);
      #1;
      chk("u2_one_cycle", {63'd0, oen2}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/max_pooling.md
MAX_POOLING -- requirements
Module: max_pooling

Interface
REQ-001 SHALL have parameter WIDTH, default -1, input frame width in pixels; even, >=2.
REQ-002 SHALL have parameter HEIGHT, default -1, input frame height in lines; even, >=2.
REQ-003 SHALL have parameter FIXED_BITW, default -1, bits per signed two's-complement feature value.
REQ-004 SHALL have parameter UNITS, default -1, feature channels per pixel.
REQ-005 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_enable, input, 1, input pixel valid this cycle.
REQ-008 SHALL have port in_pixels, input, FIXED_BITW*UNITS, [0:..] ordered, unit 0 in MSBs.
REQ-009 SHALL have ports in_vcnt / in_hcnt, input, log2(HEIGHT) / log2(WIDTH), input coordinates.
REQ-010 SHALL have port out_enable, output, 1, pooled pixel valid.
REQ-011 SHALL have port out_pixels, output, FIXED_BITW*UNITS, pooled values, same ordering.
REQ-012 SHALL have ports out_vcnt / out_hcnt, output, log2(HEIGHT)-1 / log2(WIDTH)-1 bits, in_vcnt>>1 / in_hcnt>>1 of the window.

Function
REQ-013 SHALL treat each 2x2 window {UL,UR,LL,LR} as (vcnt[0],hcnt[0]) = (0,0),(0,1),(1,0),(1,1).
REQ-014 SHALL act only on cycles with in_enable=1; gaps of any length between pixels SHALL be tolerated.
REQ-015 SHALL latch in_pixels into a pair register on an even-column pixel and set pair_valid.
REQ-016 SHALL on an odd-column pixel with pair_valid=1 form per-unit signed hmax(pair, in), then clear pair_valid.
REQ-017 SHALL ignore an odd-column pixel arriving with pair_valid=0 (no write, no output).
REQ-018 SHALL on even rows write hmax to line buffer entry in_hcnt>>1 and set that entry's valid bit.
REQ-019 SHALL on odd rows with entry valid compute per-unit max(entry, hmax), clear the valid bit, and register the result.
REQ-020 SHALL on odd rows with entry invalid produce no output.
REQ-021 SHALL assert out_enable for exactly one cycle, the cycle after the LR pixel is accepted (latency 1); out_pixels/out_vcnt/out_hcnt SHALL hold until the next output.
REQ-022 SHALL resolve ties by priority UL > UR > LL > LR.
REQ-023 SHALL compare signed; most-negative value (e.g. 8'h80) is valid input and never overflows.
REQ-024 SHALL yield exactly (WIDTH/2)*(HEIGHT/2) outputs per clean frame.

Reset
REQ-025 SHALL on rst=1 immediately force out_enable=0, out_pixels=0, out_vcnt=0, out_hcnt=0, pair_valid=0, all line-buffer valid bits=0.
REQ-026 SHALL not reset line-buffer data storage.
REQ-027 SHALL after reset mid-frame produce no output until a fresh even row and matching odd row are received.

Configuration
REQ-028 SHALL with MAX_POOLING_ARGMAX_EN defined add output out_index, 2*UNITS bits, per unit the winning position {vcnt[0],hcnt[0]}, reset 0, timed as out_pixels.
REQ-029 SHALL without MAX_POOLING_ARGMAX_EN omit out_index and all index logic; other behaviour identical.

Structure
REQ-030 SHALL place log2 function, UL/UR/LL/LR 2-bit codes, and signed per-unit max function in package max_pooling_pkg.
REQ-031 SHALL implement the WIDTH/2-entry storage as sub-module pool_line_buffer (one write port, one asynchronous-read port).

Verification (WIDTH=4, HEIGHT=4, FIXED_BITW=8, UNITS=1 unless stated)
REQ-032 SHALL cover: rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} continuous -> outputs 6,8,14,16 at (v,h)=(0,0),(0,1),(1,0),(1,1), each one cycle after its LR pixel.
REQ-033 SHALL cover: window {-128,-1,-5,-2} -> out -1; ARGMAX_EN index 2'b01.
REQ-034 SHALL cover: window {7,7,7,7} with ARGMAX_EN -> out 7, index 2'b00.
REQ-035 SHALL cover: same frame as REQ-032 with in_enable low 3 cycles between every pixel -> identical values and coordinates.
REQ-036 SHALL cover: rst pulsed after row 0 pixel 2 -> no output for rows 0-1; row pair 2-3 -> 14,16 only.
REQ-037 SHALL cover: UNITS=2, window unit0 {1,9,3,4}, unit1 {-3,-7,-1,-8} -> out {9,-1}, index {01,10}.
